// File: rtl/lif_spike_rate_display_if.sv
// Signal bundle between the LIF spike source / board logic and the spike-rate display.
// The slave modport is the rate display; the master modport drives it.
interface lif_spike_rate_display_if #(
    parameter int CNT_W = 4
);
    // No back-pressure anywhere: ena qualifies every cycle, spike_in and clear are
    // level inputs sampled on enabled edges, and window_done is a one-cycle strobe
    // that marks the cycle in which rate/segments/overflow first show a new window.
    logic             ena;
    logic             spike_in;
    logic             clear;
    logic [6:0]       segments;
    logic [CNT_W-1:0] rate;
    logic             overflow;
    logic             window_done;

    modport master (
        output ena, spike_in, clear,
        input  segments, rate, overflow, window_done
    );

    modport slave (
        input  ena, spike_in, clear,
        output segments, rate, overflow, window_done
    );
endinterface

// File: rtl/lif_spike_rate_display.sv
// Counts LIF spikes over a fixed window of enabled cycles and shows the saturated
// count as a hex digit on a 7-segment display, with an overflow flag and done strobe.
module lif_spike_rate_display #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = 4,
    parameter int EDGE_MODE     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lif_spike_rate_display_if.slave  bus
);
    localparam int               WC_W    = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WC_W-1:0]  win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic             spike_prev;
    logic             sat;
    logic [CNT_W-1:0] rate_q;
    logic [6:0]       segments_q;
    logic             overflow_q;
    logic             window_done_q;

    logic             hit;
    logic             terminal;
    logic             cnt_full;
    logic [CNT_W-1:0] next_cnt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        hit      = (EDGE_MODE != 0) ? (bus.spike_in & ~spike_prev) : bus.spike_in;
        terminal = (win_cnt == WC_W'(WINDOW_CYCLES - 1));
        cnt_full = (spk_cnt == CNT_MAX);
        // Saturating add: the count sticks at all-ones instead of wrapping.
        next_cnt = (hit && !cnt_full) ? spk_cnt + 1'b1 : spk_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt       <= '0;
            spk_cnt       <= '0;
            spike_prev    <= 1'b0;
            sat           <= 1'b0;
            rate_q        <= '0;
            segments_q    <= 7'h3F;
            overflow_q    <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            window_done_q <= 1'b0;
            if (bus.ena) begin
                if (bus.clear) begin
                    // Clear restarts the window but leaves the last result on display.
                    win_cnt    <= '0;
                    spk_cnt    <= '0;
                    spike_prev <= 1'b0;
                    sat        <= 1'b0;
                end else begin
                    spike_prev <= bus.spike_in;
                    if (terminal) begin
                        rate_q        <= next_cnt;
                        segments_q    <= hex7(4'(next_cnt));
                        overflow_q    <= sat | (hit & cnt_full);
                        window_done_q <= 1'b1;
                        spk_cnt       <= '0;
                        sat           <= 1'b0;
                        win_cnt       <= '0;
                    end else begin
                        spk_cnt <= next_cnt;
                        if (hit && cnt_full) sat <= 1'b1;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.rate        = rate_q;
    assign bus.segments    = segments_q;
    assign bus.overflow    = overflow_q;
    assign bus.window_done = window_done_q;
endmodule

// File: tb/tb_lif_spike_rate_display.sv
// Randomized and directed checks of three display instances (edge/level mode,
// 20- and 40-cycle windows) against a window-sample reference model.
module tb_lif_spike_rate_display;
    localparam int CNT_W = 4;
    localparam int N     = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic t_ena, t_spike, t_clear;

    lif_spike_rate_display_if #(.CNT_W(CNT_W)) bus0 ();
    lif_spike_rate_display_if #(.CNT_W(CNT_W)) bus1 ();
    lif_spike_rate_display_if #(.CNT_W(CNT_W)) bus2 ();

    assign bus0.ena = t_ena;  assign bus0.spike_in = t_spike;  assign bus0.clear = t_clear;
    assign bus1.ena = t_ena;  assign bus1.spike_in = t_spike;  assign bus1.clear = t_clear;
    assign bus2.ena = t_ena;  assign bus2.spike_in = t_spike;  assign bus2.clear = t_clear;

    lif_spike_rate_display #(.WINDOW_CYCLES(20), .CNT_W(CNT_W), .EDGE_MODE(1)) u_edge20 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    lif_spike_rate_display #(.WINDOW_CYCLES(20), .CNT_W(CNT_W), .EDGE_MODE(0)) u_lvl20 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    lif_spike_rate_display #(.WINDOW_CYCLES(40), .CNT_W(CNT_W), .EDGE_MODE(1)) u_edge40 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [6:0]       d_seg  [N];
    logic [CNT_W-1:0] d_rate [N];
    logic             d_ovf  [N];
    logic             d_done [N];
    assign d_seg[0] = bus0.segments; assign d_rate[0] = bus0.rate;
    assign d_ovf[0] = bus0.overflow; assign d_done[0] = bus0.window_done;
    assign d_seg[1] = bus1.segments; assign d_rate[1] = bus1.rate;
    assign d_ovf[1] = bus1.overflow; assign d_done[1] = bus1.window_done;
    assign d_seg[2] = bus2.segments; assign d_rate[2] = bus2.rate;
    assign d_ovf[2] = bus2.overflow; assign d_done[2] = bus2.window_done;

    // ---------------- reference model ----------------
    int         win_len [N] = '{20, 20, 40};
    bit         edge_m  [N] = '{1'b1, 1'b0, 1'b1};
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Enabled, non-cleared spike samples of the window in progress.
    bit         win_q      [N][$];
    bit         start_prev [N];
    int         m_rate     [N];
    bit         m_ovf      [N];
    bit         m_done     [N];

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic model_step(input bit r, input bit e, input bit s, input bit c);
        for (int i = 0; i < N; i++) begin
            if (!r) begin
                win_q[i].delete();
                start_prev[i] = 1'b0;
                m_rate[i] = 0; m_ovf[i] = 1'b0; m_done[i] = 1'b0;
            end else if (!e) begin
                m_done[i] = 1'b0;
            end else if (c) begin
                win_q[i].delete();
                start_prev[i] = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                win_q[i].push_back(s);
                m_done[i] = 1'b0;
                if (win_q[i].size() == win_len[i]) begin
                    int n = 0;
                    for (int j = 0; j < win_len[i]; j++) begin
                        bit prev;
                        prev = (j == 0) ? start_prev[i] : win_q[i][j-1];
                        if (edge_m[i] ? (win_q[i][j] && !prev) : win_q[i][j]) n++;
                    end
                    m_rate[i] = (n > 15) ? 15 : n;
                    m_ovf[i]  = (n > 15);
                    m_done[i] = 1'b1;
                    start_prev[i] = win_q[i][win_len[i]-1];
                    win_q[i].delete();
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int got, input int exp);
        cmp_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("rate[%0d]", i),  int'(d_rate[i]), m_rate[i]);
            check($sformatf("seg[%0d]", i),   int'(d_seg[i]),  int'(hex_tab[m_rate[i]]));
            check($sformatf("ovf[%0d]", i),   int'(d_ovf[i]),  int'(m_ovf[i]));
            check($sformatf("done[%0d]", i),  int'(d_done[i]), int'(m_done[i]));
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change just after a falling edge, the DUT samples them on the next
    // rising edge, and outputs are compared on the following falling edge.
    task automatic step(input bit r, input bit e, input bit s, input bit c);
        rst_n = r; t_ena = e; t_spike = s; t_clear = c;
        model_step(r, e, s, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; t_ena = 1'b1; t_spike = 1'b0; t_clear = 1'b0;

        // Reset held for three cycles with ena high.
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0);
        check("lit_reset_rate", int'(d_rate[0]), 0);
        check("lit_reset_seg",  int'(d_seg[0]),  'h3F);
        check("lit_reset_ovf",  int'(d_ovf[0]),  0);
        check("lit_reset_done", int'(d_done[0]), 0);

        // Basic count: five single-cycle pulses in the first 20-cycle window.
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, (k == 2 || k == 5 || k == 8 || k == 11 || k == 14), 0);
            if (k == 19) check("lit_first_done_early", int'(d_done[0]), 0);
        end
        check("lit_basic_done", int'(d_done[0]), 1);
        check("lit_basic_rate", int'(d_rate[0]), 5);
        check("lit_basic_seg",  int'(d_seg[0]),  'h6D);
        check("lit_basic_ovf",  int'(d_ovf[0]),  0);
        check("lit_basic_lvl",  int'(d_rate[1]), 5);

        // Spike held high for a whole window: edge vs level.
        for (int k = 1; k <= 20; k++) step(1, 1, 1, 0);
        check("lit_held_edge_rate", int'(d_rate[0]), 1);
        check("lit_held_edge_seg",  int'(d_seg[0]),  'h06);
        check("lit_held_lvl_rate",  int'(d_rate[1]), 15);
        check("lit_held_lvl_seg",   int'(d_seg[1]),  'h71);
        check("lit_held_lvl_ovf",   int'(d_ovf[1]),  1);
        step(1, 1, 0, 0);
        check("lit_done_one_cycle", int'(d_done[0]), 0);

        // Clear mid-window: 3 pulses, clear, then 2 pulses in a fresh 20-cycle window.
        for (int k = 1; k <= 8; k++) step(1, 1, (k == 2 || k == 4 || k == 6), 0);
        step(1, 1, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, (k == 3 || k == 7), 0);
            if (k == 19) begin
                check("lit_clear_hold_rate", int'(d_rate[0]), 1);
                check("lit_clear_no_done",   int'(d_done[0]), 0);
            end
        end
        check("lit_clear_rate", int'(d_rate[0]), 2);
        check("lit_clear_done", int'(d_done[0]), 1);

        // Clear on the terminal cycle: no latch, no strobe.
        run_idle(19);
        step(1, 1, 1, 1);
        check("lit_term_clear_done", int'(d_done[0]), 0);
        check("lit_term_clear_rate", int'(d_rate[0]), 2);

        // Saturation on the 40-cycle edge instance, then a lone terminal-cycle hit.
        step(0, 1, 0, 0);
        for (int k = 1; k <= 40; k++) step(1, 1, k[0], 0);
        check("lit_sat_rate", int'(d_rate[2]), 15);
        check("lit_sat_ovf",  int'(d_ovf[2]),  1);
        for (int k = 1; k <= 40; k++) step(1, 1, (k == 40), 0);
        check("lit_term_hit_rate", int'(d_rate[2]), 1);
        check("lit_term_hit_ovf",  int'(d_ovf[2]),  0);
        check("lit_term_hit_done", int'(d_done[2]), 1);

        // Enable freeze: 7 disabled cycles of toggling are ignored.
        step(0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) step(1, 1, (k == 2 || k == 4), 0);
        for (int k = 1; k <= 7; k++) step(1, 0, k[0], 0);
        for (int k = 1; k <= 15; k++) begin
            step(1, 1, (k == 3), 0);
            if (k == 14) check("lit_freeze_not_yet", int'(d_done[0]), 0);
        end
        check("lit_freeze_done", int'(d_done[0]), 1);
        check("lit_freeze_rate", int'(d_rate[0]), 3);

        // Randomized traffic with varying spike density per block.
        for (int b = 0; b < 80; b++) begin
            int dens;
            dens = $urandom_range(0, 100);
            for (int k = 0; k < 40; k++) begin
                bit r, e, s, c;
                r = ($urandom_range(0, 599) != 0);
                e = ($urandom_range(0, 9) != 0);
                s = ($urandom_range(0, 99) < dens);
                c = ($urandom_range(0, 59) == 0);
                step(r, e, s, c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/lif_spike_rate_display.md
Name: lif_spike_rate_display

Overview:
Downstream stage of the HLS LIF neuron core. It consumes the neuron's 1-bit spike output and counts spikes over a fixed measurement window of clock cycles. At the end of each window it latches the saturated count and drives it as a hex digit onto the top-level 7-segment output (uo_out[6:0]). It gives a human-readable firing rate on the Tiny Tapeout demo board.

Parameters:
WINDOW_CYCLES, 1000, number of enabled clock cycles per measurement window (>=2)
CNT_W, 4, width of spike count and displayed rate; count saturates at 2^CNT_W-1
EDGE_MODE, 1, 1 = count rising edges of spike_in; 0 = count every cycle spike_in is high

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
ena  input  1  design enable; when low all internal state freezes
spike_in  input  1  spike output of the LIF core
clear  input  1  synchronous clear; restarts the current window
segments  output  7  active-high 7-seg, bit0=a … bit6=g, hex decode of rate
rate  output  CNT_W  latched spike count of last completed window
overflow  output  1  last completed window saturated
window_done  output  1  one-cycle pulse; rate/segments just updated

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on rising clk.
- Reset values:
  - win_cnt=0, spk_cnt=0, spike_prev=0, sat flag=0
  - rate=0, segments=7'h3F ("0"), overflow=0, window_done=0
- All outputs are registered; segments is a registered decode, updated on the same edge as rate.
- ena=0:
  - win_cnt, spk_cnt, spike_prev and the sat flag hold their values.
  - window_done=0.
  - rate, segments and overflow hold.
- Spike qualifier:
  - EDGE_MODE=1: hit = spike_in & ~spike_prev. spike_prev <= spike_in on every enabled cycle.
  - EDGE_MODE=0: hit = spike_in.
- Window counter: win_cnt counts 0..WINDOW_CYCLES-1 on enabled cycles. The terminal cycle is win_cnt==WINDOW_CYCLES-1.
- Non-terminal enabled cycle:
  - If hit and spk_cnt==max, spk_cnt holds at max and sat<=1.
  - Otherwise, if hit, spk_cnt+1.
- Terminal enabled cycle:
  - next = sat_add(spk_cnt, hit). A hit on the terminal cycle belongs to this window.
  - rate <= next, segments <= hex(next).
  - overflow <= sat | (hit & spk_cnt==max).
  - window_done <= 1.
  - spk_cnt <= 0, sat <= 0, win_cnt <= 0.
- window_done is high for exactly the one cycle following the terminal edge; it is 0 otherwise.
- clear=1 on an enabled cycle:
  - win_cnt, spk_cnt, sat and spike_prev go to 0.
  - rate, segments and overflow hold.
  - window_done=0.
- clear on the terminal cycle: clear wins. No latch, no window_done pulse.
- clear is ignored while ena=0.
- Reset mid-window: all state returns to reset values and the display shows "0".
- Hex decode (g..a):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- If CNT_W>4, segments decodes rate[3:0]. The rate port carries the full width.
- Width rule: the counter never wraps; saturation is exact at 2^CNT_W-1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, ena=1 -> rate=0, segments=7'h3F, overflow=0, window_done=0. Release reset -> first window_done exactly WINDOW_CYCLES cycles later.
- Basic count (WINDOW_CYCLES=20, EDGE_MODE=1): 5 single-cycle pulses on spike_in within the window -> at window end rate=5, segments=7'h6D, overflow=0. window_done is high for 1 cycle.
- Edge vs level: spike_in held high for a whole 20-cycle window:
  - EDGE_MODE=1 -> rate=1, segments=7'h06.
  - EDGE_MODE=0 -> rate=15, segments=7'h71, overflow=1.
- Saturation and terminal hit (WINDOW_CYCLES=40, EDGE_MODE=1): toggle spike_in every cycle (20 edges) -> rate=15, overflow=1. Next window has exactly 1 pulse, on its final cycle -> rate=1, overflow=0.
- Clear: 3 pulses, then clear at cycle 10 of window, then 2 pulses -> the window ends 20 cycles after clear with rate=2. The display keeps its prior value until then. clear asserted on a terminal cycle -> no window_done.
- Enable freeze: drop ena for 7 cycles mid-window while toggling spike_in -> no hits counted. window_done arrives 7 cycles late and rate counts only pulses seen with ena=1.
